// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Two-requester arbiter for a single shared memory port.
//   - Requester A is instruction fetch and requester B is data access.
//   - When both requesters ask at the same time, the one not served last wins.
//   - Address, write data and write enable are captured when a grant starts.
//     The shared port is driven only from those captured registers.
//   - A transaction ends on mem_ack. The owner then gets a one-cycle done pulse.
//     The shared port returns to IDLE for at least one cycle.
//
// Ports
//   Clk, Rst                 clock and asynchronous active-high reset
//   req_x/addr_x/wdata_x/we_x  requester A and B access requests
//   gnt_x, done_x            grant level and completion pulse per requester
//   rdata                    data of the last completed read
//   sel                      data-mux owner select (0 = A, 1 = B)
//   mem_*                    shared memory port
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              req_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              we_a,
    input  logic              req_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    input  logic              we_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              done_a,
    output logic              done_b,
    output logic [DATA_W-1:0] rdata,
    output logic              sel,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_A = 2'd1,
        BUSY_B = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_start;       // IDLE -> BUSY_x this cycle
    logic                w_finish;      // BUSY_x completes this cycle
    logic                r_last_b;      // 1 = B was served last
    logic                r_gnt_a;
    logic                r_gnt_b;
    logic                r_mem_req;
    logic                r_done_a;
    logic                r_done_b;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_we;
    logic [DATA_W-1:0]   r_rdata;

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. On a tie, the requester that did not go last wins.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_a && (!req_b || r_last_b)) begin
                    w_state_next = BUSY_A;
                    w_start      = 1'b1;
                end else if (req_b) begin
                    w_state_next = BUSY_B;
                    w_start      = 1'b1;
                end
            end
            BUSY_A, BUSY_B: begin
                if (mem_ack) begin
                    w_state_next = IDLE;
                    w_finish     = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Grant, request and select outputs come from flops loaded with the
    // decoded next state. This keeps them glitch-free and equal to the
    // decode of r_state at all times.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_gnt_a   <= 1'b0;
            r_gnt_b   <= 1'b0;
            r_mem_req <= 1'b0;
            r_done_a  <= 1'b0;
            r_done_b  <= 1'b0;
            r_last_b  <= 1'b1;
        end else begin
            r_gnt_a   <= (w_state_next == BUSY_A);
            r_gnt_b   <= (w_state_next == BUSY_B);
            r_mem_req <= (w_state_next != IDLE);
            r_done_a  <= w_finish && (r_state == BUSY_A);
            r_done_b  <= w_finish && (r_state == BUSY_B);
            if (w_finish) begin
                r_last_b <= (r_state == BUSY_B);
            end
        end
    end

    // Capture the winner's request so that input churn during BUSY has no effect.
    // Read data is loaded only when a read completes.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_start) begin
                if (w_state_next == BUSY_B) begin
                    r_addr  <= addr_b;
                    r_wdata <= wdata_b;
                    r_we    <= we_b;
                end else begin
                    r_addr  <= addr_a;
                    r_wdata <= wdata_a;
                    r_we    <= we_a;
                end
            end
            if (w_finish && !r_we) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign gnt_a     = r_gnt_a;
    assign gnt_b     = r_gnt_b;
    assign sel       = r_gnt_b;
    assign mem_req   = r_mem_req;
    assign done_a    = r_done_a;
    assign done_b    = r_done_b;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_we    = r_we;
    assign rdata     = r_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Inputs are driven and outputs are
//   sampled 1 ns after each rising clock edge. Each check prints one line.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 32;

    logic              Clk;
    logic              Rst;
    logic              req_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wdata_a;
    logic              we_a;
    logic              req_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b;
    logic              we_b;
    logic              gnt_a;
    logic              gnt_b;
    logic              done_a;
    logic              done_b;
    logic [DATA_W-1:0] rdata;
    logic              sel;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    int n_checks;
    int n_pass;
    int gnt_cycles;

    mem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .req_a     (req_a),
        .addr_a    (addr_a),
        .wdata_a   (wdata_a),
        .we_a      (we_a),
        .req_b     (req_b),
        .addr_b    (addr_b),
        .wdata_b   (wdata_b),
        .we_b      (we_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .done_a    (done_a),
        .done_b    (done_b),
        .rdata     (rdata),
        .sel       (sel),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("ok   %-16s obs=%h exp=%h", tag, obs, exp);
        end else begin
            $display("FAIL %-16s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Serve one tie-broken transaction while both requests are held high.
    task automatic serve(input logic exp_b, input logic [63:0] data);
        tick();
        chk("tie_gnt_a", {63'd0, gnt_a}, {63'd0, !exp_b});
        chk("tie_gnt_b", {63'd0, gnt_b}, {63'd0, exp_b});
        chk("tie_sel",   {63'd0, sel},   {63'd0, exp_b});
        mem_ack   = 1'b1;
        mem_rdata = data;
        tick();
        chk("tie_done", {62'd0, done_b, done_a}, exp_b ? 64'd2 : 64'd1);
        chk("tie_rdata", rdata, data);
        chk("tie_idle",  {63'd0, mem_req}, 64'd0);
        mem_ack = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        Rst       = 1'b1;
        req_a     = 1'b0;
        addr_a    = '0;
        wdata_a   = '0;
        we_a      = 1'b0;
        req_b     = 1'b0;
        addr_b    = '0;
        wdata_b   = '0;
        we_b      = 1'b0;
        mem_rdata = '0;
        mem_ack   = 1'b0;

        // Reset state
        tick();
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_gnt",     {62'd0, gnt_b, gnt_a}, 64'd0);
        chk("rst_rdata",   rdata, 64'd0);
        chk("rst_addr",    {32'd0, mem_addr}, 64'd0);
        Rst = 1'b0;
        tick();

        // Single read from A with an ack three cycles after the grant
        req_a  = 1'b1;
        addr_a = 32'h100;
        gnt_cycles = 0;
        tick();
        chk("rd_mem_addr", {32'd0, mem_addr}, 64'h100);
        chk("rd_sel",      {63'd0, sel}, 64'd0);
        chk("rd_mem_we",   {63'd0, mem_we}, 64'd0);
        req_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (gnt_a) gnt_cycles++;
            if (i == 2) begin
                mem_ack   = 1'b1;
                mem_rdata = 64'hDEADBEEF_CAFEF00D;
            end
            tick();
        end
        chk("rd_gnt_cycles", 64'(gnt_cycles), 64'd3);
        chk("rd_done_a",     {63'd0, done_a}, 64'd1);
        chk("rd_gnt_off",    {63'd0, gnt_a}, 64'd0);
        chk("rd_rdata",      rdata, 64'hDEADBEEF_CAFEF00D);
        mem_ack = 1'b0;
        tick();
        chk("rd_done_pulse", {63'd0, done_a}, 64'd0);

        // Reset again so the tie starts from the reset arbitration state
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        req_a  = 1'b1;
        req_b  = 1'b1;
        addr_a = 32'hA0;
        addr_b = 32'hB0;
        serve(1'b0, 64'h11);
        serve(1'b1, 64'h22);
        serve(1'b0, 64'h33);
        serve(1'b1, 64'h44);
        req_a = 1'b0;
        req_b = 1'b0;
        tick();

        // Preload rdata to 0x55 using an A read
        req_a  = 1'b1;
        addr_a = 32'h10;
        tick();
        req_a     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 64'h55;
        tick();
        mem_ack = 1'b0;
        tick();

        // A write from B leaves rdata unchanged
        req_b   = 1'b1;
        we_b    = 1'b1;
        addr_b  = 32'h200;
        wdata_b = 64'h1234;
        tick();
        chk("wr_gnt_b",  {63'd0, gnt_b}, 64'd1);
        chk("wr_mem_we", {63'd0, mem_we}, 64'd1);
        chk("wr_wdata",  mem_wdata, 64'h1234);
        req_b     = 1'b0;
        we_b      = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 64'hFFFF;
        tick();
        chk("wr_done_b", {63'd0, done_b}, 64'd1);
        chk("wr_rdata",  rdata, 64'h55);
        mem_ack = 1'b0;
        tick();

        // Changing A's inputs during BUSY_A does not affect the transaction
        req_a  = 1'b1;
        addr_a = 32'h300;
        tick();
        chk("churn_addr0", {32'd0, mem_addr}, 64'h300);
        req_a   = 1'b0;
        addr_a  = 32'h999;
        wdata_a = 64'h7;
        we_a    = 1'b1;
        tick();
        chk("churn_addr1", {32'd0, mem_addr}, 64'h300);
        chk("churn_gnt",   {63'd0, gnt_a}, 64'd1);
        chk("churn_we",    {63'd0, mem_we}, 64'd0);
        mem_ack   = 1'b1;
        mem_rdata = 64'h77;
        tick();
        chk("churn_done",  {63'd0, done_a}, 64'd1);
        chk("churn_rdata", rdata, 64'h77);
        mem_ack = 1'b0;
        we_a    = 1'b0;
        tick();

        // An ack while IDLE is ignored
        mem_ack   = 1'b1;
        mem_rdata = 64'hBAD;
        tick();
        chk("stray_done",  {62'd0, done_b, done_a}, 64'd0);
        chk("stray_req",   {63'd0, mem_req}, 64'd0);
        chk("stray_rdata", rdata, 64'h77);
        mem_ack = 1'b0;
        tick();

        // Reset during BUSY_B takes effect between edges
        req_b  = 1'b1;
        addr_b = 32'h400;
        tick();
        chk("mr_gnt_b", {63'd0, gnt_b}, 64'd1);
        chk("mr_sel",   {63'd0, sel}, 64'd1);
        req_b = 1'b0;
        #2;
        Rst = 1'b1;
        #1;
        chk("mr_async_req", {63'd0, mem_req}, 64'd0);
        chk("mr_async_gnt", {63'd0, gnt_b}, 64'd0);
        chk("mr_async_sel", {63'd0, sel}, 64'd0);
        mem_ack = 1'b1;
        tick();
        chk("mr_no_done", {63'd0, done_b}, 64'd0);
        Rst     = 1'b0;
        mem_ack = 1'b0;
        req_a   = 1'b1;
        req_b   = 1'b1;
        tick();
        chk("mr_tie_gnt_a", {63'd0, gnt_a}, 64'd1);
        chk("mr_tie_gnt_b", {63'd0, gnt_b}, 64'd0);
        chk("mr_done_b",    {63'd0, done_b}, 64'd0);
        req_a   = 1'b0;
        req_b   = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DATA_W  64  width of data words on all ports
  ADDR_W  32  width of byte addresses on all ports
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
  Clk        in   1       rising-edge clock
  Rst        in   1       asynchronous active-high reset
  req_a      in   1       requester A (instruction fetch) access request
  addr_a     in   ADDR_W  requester A address
  wdata_a    in   DATA_W  requester A write data
  we_a       in   1       requester A write enable (0 = read)
  req_b      in   1       requester B (data access) access request
  addr_b     in   ADDR_W  requester B address
  wdata_b    in   DATA_W  requester B write data
  we_b       in   1       requester B write enable
  gnt_a      out  1       A owns the memory port
  gnt_b      out  1       B owns the memory port
  done_a     out  1       one-cycle pulse: A transaction complete
  done_b     out  1       one-cycle pulse: B transaction complete
  rdata      out  DATA_W  registered read data of the last completed read
  sel        out  1       owner select for the shared 64-bit data mux (0 = A, 1 = B)
  mem_req    out  1       shared port request
  mem_addr   out  ADDR_W  shared port address
  mem_wdata  out  DATA_W  shared port write data
  mem_we     out  1       shared port write enable
  mem_rdata  in   DATA_W  shared port read data, valid with mem_ack
  mem_ack    in   1       shared port completion strobe

Function
REQ-004 FSM SHALL have exactly three states: IDLE, BUSY_A, BUSY_B.
REQ-005 From IDLE, only req_a -> BUSY_A; only req_b -> BUSY_B; neither -> stay in IDLE.
REQ-006 From IDLE with req_a and req_b both high, the requester not served last SHALL win, using a registered last_b flag (1 = B served last).
REQ-007 On the IDLE->BUSY_x edge, addr_x, wdata_x and we_x SHALL be captured into internal registers; mem_addr, mem_wdata and mem_we SHALL be driven only from these registers.
REQ-008 mem_req SHALL be 1 exactly while in BUSY_A or BUSY_B; gnt_a = (state == BUSY_A); gnt_b = (state == BUSY_B); sel = gnt_b; all are state-decoded and glitch-free.
REQ-009 BUSY_x with mem_ack = 1 SHALL: return to IDLE; pulse done_x high for exactly the next cycle; set last_b = (x == B); load rdata from mem_rdata only if the captured we = 0.
REQ-010 Without mem_ack, BUSY_x SHALL hold indefinitely; there is no timeout.
REQ-011 Latency: req sampled at edge N -> mem_req high after edge N; mem_ack sampled at edge M -> done_x high for cycle M..M+1 and mem_req low after edge M.
REQ-012 At least one IDLE cycle SHALL separate back-to-back transactions.
REQ-013 Deasserting req_x or changing addr_x/wdata_x/we_x during BUSY_x SHALL NOT abort or alter the transaction in flight.
REQ-014 mem_ack in IDLE SHALL be ignored: no state change, no done pulse, rdata unchanged.
REQ-015 Write transactions SHALL leave rdata unchanged.

Reset
REQ-016 Rst = 1 SHALL immediately, without waiting for a clock edge, force: state = IDLE; last_b = 1 (A wins the first tie); gnt_a, gnt_b, done_a, done_b, sel, mem_req, mem_we = 0; mem_addr, mem_wdata, rdata = 0.
REQ-017 Reset during BUSY_x SHALL abandon the transaction with no done pulse.
REQ-018 After Rst deasserts, arbitration SHALL resume at the first rising edge.

Verification
REQ-019 Bench SHALL cover the following:
  - Single read: req_a, addr_a = 0x100; mem_ack 3 cycles later with mem_rdata = 0xDEADBEEF_CAFEF00D -> gnt_a high for 3 cycles, done_a pulse for 1 cycle, rdata = 0xDEADBEEF_CAFEF00D, sel = 0.
  - Tie after reset: req_a and req_b high together -> A served first, then B after one IDLE cycle, with sel = 1 during BUSY_B; hold both requests -> grants alternate A, B, A, B.
  - Write from B: we_b = 1, wdata_b = 0x1234, rdata previously 0x55 -> mem_we = 1, mem_wdata = 0x1234, done_b pulses, rdata stays 0x55.
  - Input churn: change addr_a and drop req_a during BUSY_A -> mem_addr stays at the captured value and the transaction completes normally.
  - Stray ack: mem_ack pulsed in IDLE -> no done pulse, state and rdata unchanged.
  - Mid-transaction reset: Rst asserted between clock edges during BUSY_B -> mem_req, gnt_b and sel drop before the next edge, no done_b pulse, and the next tie goes to A.
